// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the round-robin Gray-code arbiter.
package gray_arb_pkg;

    localparam int unsigned WIDTH_DEF = 5;
    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned LEN_W_DEF = 5;
    localparam int unsigned IDX_W     = $clog2(NREQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_gen.sv
// Binary counter with advance, and a registered Gray view of its next value.
module gray_gen
    import gray_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    output logic [WIDTH-1:0] gray_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    always_comb begin
        count_d = count_q;
        if (adv_i) begin
            count_d = count_q + WIDTH'(1);
        end
        gray_d = WIDTH'(bin2gray(32'(count_d)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            gray_q  <= '0;
        end else begin
            count_q <= count_d;
            gray_q  <= gray_d;
        end
    end

    assign gray_o = gray_q;

endmodule

// File: rtl/gray_arb_ctrl.sv
// Round-robin arbiter handing bursts of one shared Gray sequence to requesters.
// Optional adjacency checker: define GRAY_ARB_CTRL_CHECK_EN.
module gray_arb_ctrl
    import gray_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         grant,
    output logic [WIDTH-1:0]        gray_out,
    output logic                    gray_valid,
    input  logic                    gray_ready,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic                    gray_err
);

    localparam int unsigned ID_W   = $clog2(NREQ);
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   winner_q, winner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;

    logic [ID_W-1:0]   pick_c;
    logic [ID_W:0]     idx_c;
    logic [LEN_W-1:0]  len_c;
    logic              adv_c;

    // First set request at or after rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        pick_c = rr_ptr_q;
        idx_c  = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx_c = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (idx_c >= NREQ_W) begin
                idx_c = idx_c - NREQ_W;
            end
            if (req[ID_W'(idx_c)]) begin
                pick_c = ID_W'(idx_c);
            end
        end
    end

    always_comb begin
        len_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ID_W'(i) == pick_c) begin
                len_c = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        grant_d     = '0;
        valid_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        adv_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    winner_d    = pick_c;
                    remaining_d = len_c;
                    grant_d     = NREQ'(1) << pick_c;
                    busy_d      = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                grant_d = grant_q;
                busy_d  = 1'b1;
                valid_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                grant_d = grant_q;
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (valid_q && gray_ready) begin
                    adv_c = 1'b1;
                    if (remaining_q == '0) begin
                        grant_d   = '0;
                        busy_d    = 1'b0;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                        done_id_d = winner_q;
                        state_d   = DONE;
                    end else begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end
            end
            DONE: begin
                rr_ptr_d = (winner_q == LAST_ID) ? '0 : winner_q + ID_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    gray_gen #(
        .WIDTH (WIDTH)
    ) u_gray_gen (
        .clk    (clk),
        .reset  (reset),
        .adv_i  (adv_c),
        .gray_o (gray_out)
    );

`ifdef GRAY_ARB_CTRL_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             prev_vld_q;
    logic             err_q;

    // Every accepted code must differ from the previous accepted code in one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (adv_c) begin
            prev_q     <= gray_out;
            prev_vld_q <= 1'b1;
            if (prev_vld_q && ($countones(gray_out ^ prev_q) != 1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign gray_err = err_q;
`else
    assign gray_err = 1'b0;
`endif

    assign grant      = grant_q;
    assign gray_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;

endmodule

// File: doc/gray_arb_ctrl.md
Name: gray_arb_ctrl

Overview:
- Shares one Gray-code generator between NREQ requesters using round-robin arbitration.
- A granted requester receives a burst of (len+1) consecutive Gray codes over a valid/ready handshake.
- The underlying binary count persists across bursts, so the global code sequence stays continuous and single-bit-stepping.
- Sits between the Gray counter datapath and its consumers; it sequences enable/advance for the counter.

Parameters:
- WIDTH, 5: Gray code / internal count width.
- NREQ, 4: number of requesters, 2..8.
- LEN_W, 5: width of each burst-length field.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  level request per requester; held until its done pulse.
- req_len  input  NREQ*LEN_W  per-requester burst length minus 1; field i is bits [i*LEN_W +: LEN_W].
- grant  output  NREQ  one-hot grant, registered.
- gray_out  output  WIDTH  current Gray code, equal to count ^ (count>>1).
- gray_valid  output  1  gray_out is offered to the granted requester.
- gray_ready  input  1  granted requester accepts gray_out.
- busy  output  1  high in GRANT/RUN.
- done  output  1  one-cycle pulse when the last code of a burst is accepted.
- done_id  output  $clog2(NREQ)  index of the requester whose burst finished; valid with done.
- gray_err  output  1  sticky adjacency-check error (see Optional Feature).

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, count=0, remaining=0, rr_ptr=0 (req0 highest priority).
  - Outputs: grant=0, gray_out=0, gray_valid=0, busy=0, done=0, done_id=0, gray_err=0.
  - Reset mid-burst aborts the burst immediately, with no done pulse.
- FSM states: IDLE, GRANT, RUN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward, wrapping.
  - Register winner and remaining=req_len[winner]; go to GRANT.
- GRANT (1 cycle):
  - grant[winner]=1, busy=1, gray_valid=0; go to RUN.
  - Latency: req high at edge n -> grant at n+1 -> first gray_valid at n+2.
- RUN:
  - gray_valid=1, grant held.
  - On gray_valid && gray_ready: count <= count+1, wrapping mod 2^WIDTH.
    - If remaining==0: go to DONE.
    - Otherwise remaining <= remaining-1.
  - gray_ready low: hold gray_out, count and remaining unchanged, no timeout.
  - Dropping req mid-burst is ignored; the burst completes.
- DONE (1 cycle):
  - done=1, done_id=winner, grant=0, gray_valid=0, busy=0.
  - rr_ptr <= (winner+1) mod NREQ; go to IDLE.
  - A req still high is treated as a new request next arbitration, at lowest priority.
- gray_out is always registered from count. When not valid it shows the next code to be issued.
- Burst length: req_len=0 gives 1 code; all-ones gives 2^LEN_W codes.
- Wrap: count 2^WIDTH-1 -> 0 and Gray wraps (e.g. 10000 -> 00000 for WIDTH=5). This is legal mid-burst.
- Simultaneous: new req arrivals during GRANT/RUN/DONE only affect the next IDLE arbitration.

Optional Feature:
- Macro: GRAY_ARB_CTRL_CHECK_EN.
- Defined:
  - Each accepted transfer compares the new gray_out with the previous accepted code.
  - Hamming distance !=1 sets gray_err, sticky until reset.
  - The first transfer after reset is not compared.
- Undefined: gray_err is tied to 0 and no compare logic is built.

Decomposition:
- Package gray_arb_pkg holds:
  - state enum (IDLE, GRANT, RUN, DONE);
  - bin2gray function;
  - localparam IDX_W = $clog2(NREQ) default helper.
- One sub-module, gray_gen: WIDTH-bit counter with advance and synchronous reset, plus registered bin2gray output.
- Arbiter and FSM stay in gray_arb_ctrl.

Test Plan:
- Single burst: after reset, req=0001, req_len[0]=3, ready=1.
  - grant=0001 at cycle 1; codes 00000, 00001, 00011, 00010 at cycles 2-5.
  - done=1 with done_id=0 at cycle 6.
- Continuity: after the single burst, req1 with len 1 -> codes 00110, 00111, then done_id=1.
- Round robin: req=0101 held constantly from reset -> grant order 0001, 0100, 0001, 0100; each burst preceded by a grant-only cycle.
- Backpressure: ready low for 3 cycles mid-burst -> gray_out and remaining frozen, no count advance; resumes with the next code.
- Wrap: issue 33 codes via bursts -> code after 10000 is 00000. With GRAY_ARB_CTRL_CHECK_EN defined, gray_err stays 0 throughout; undefined, gray_err is constant 0.
- Reset mid-burst: reset during RUN -> next cycle grant=0, valid=0, gray_out=0, no done. The following req0 burst starts at 00000.
